// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN batch harness.
// No logic: constants, the controller state encoding and the timeout digit.
// Backpressure: n/a.
package snn_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int NUM_PIX_DEF = 784;
    localparam int ADDR_W_DEF  = 10;

    localparam logic [DIGIT_W_DEF-1:0] DIGIT_TIMEOUT = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_LABEL  = 3'd3,
        ST_START  = 3'd4,
        ST_RUN    = 3'd5,
        ST_REPORT = 3'd6,
        ST_DONE   = 3'd7
    } batch_state_t;

endpackage

// File: rtl/pix_serializer.sv
// Turns one packed-pixel byte into 1-bit RAM writes, LSB first, at consecutive addresses.
// Latency: first write the cycle after load, then one bit per cycle for nbits cycles.
// Backpressure: none; the caller must not load while a byte is still shifting.
module pix_serializer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [7:0]        byte_dat,
    input  logic [3:0]        nbits,
    input  logic [ADDR_W-1:0] base,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              data,
    output logic              last
);

    logic [7:0]        sh;
    logic [3:0]        left;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            left   <= '0;
            addr_q <= '0;
        end else if (load) begin
            sh     <= byte_dat;
            left   <= nbits;
            addr_q <= base;
        end else if (left != 4'd0) begin
            sh     <= sh >> 1;
            left   <= left - 4'd1;
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    assign we   = (left != 4'd0);
    assign addr = addr_q;
    assign data = we & sh[0];
    assign last = (left == 4'd1);

endmodule

// File: rtl/snn_batch_ctrl.sv
// Batch harness: loads each image into the input RAM, runs snn_core with a timeout, scores it.
// Latency: result strobe one cycle after core_done, or MAX_CYC cycles after core_start on timeout.
// Backpressure: rx_rdy only in RECV/LABEL; the sender holds rx_data/rx_vld until accepted.
module snn_batch_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_PIX = NUM_PIX_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int NUM_IMG = 32,
    parameter int MAX_CYC = 65535,
    parameter int CNT_W   = $clog2(NUM_IMG + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               batch_go,
    input  logic [7:0]         rx_data,
    input  logic               rx_vld,
    output logic               rx_rdy,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_data,
    input  logic [ADDR_W-1:0]  core_addr,
    output logic               core_start,
    input  logic               core_done,
    input  logic [DIGIT_W-1:0] core_digit,
    output logic               res_vld,
    output logic [DIGIT_W-1:0] res_digit,
    output logic [DIGIT_W-1:0] res_label,
    output logic               res_match,
    output logic [CNT_W-1:0]   img_cnt,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic               batch_done,
    output logic               timeout_err
);

    localparam int PIX_W = ($clog2(NUM_PIX + 1) > 4) ? $clog2(NUM_PIX + 1) : 4;
    localparam int CYC_W = $clog2(MAX_CYC + 1);
    localparam logic [PIX_W-1:0] PIX_END  = PIX_W'(NUM_PIX);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_IMG);
    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(NUM_IMG - 1);

    batch_state_t      state;
    logic [PIX_W-1:0]  pix_idx;
    logic [PIX_W-1:0]  pix_left;
    logic [3:0]        nbits;
    logic [CYC_W-1:0]  run_cyc;
    logic [DIGIT_W-1:0] label_q;
    logic              ser_load;
    logic              ser_we;
    logic              ser_data;
    logic              ser_last;
    logic [ADDR_W-1:0] ser_addr;

    // pix_idx advances by a whole byte's worth at load time, so it already
    // points past the byte being shifted while in SHIFT.
    assign pix_left = PIX_END - pix_idx;
    assign nbits    = (pix_left >= PIX_W'(8)) ? 4'd8 : pix_left[3:0];
    assign ser_load = (state == ST_RECV) && rx_vld;

    assign rx_rdy     = (state == ST_RECV) || (state == ST_LABEL);
    assign core_start = (state == ST_START);
    assign res_vld    = (state == ST_REPORT);
    assign ram_we     = ser_we;
    assign ram_data   = ser_data;
    assign ram_addr   = (state == ST_RUN) ? core_addr : ser_addr;

    pix_serializer #(.ADDR_W(ADDR_W)) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .byte_dat (rx_data),
        .nbits    (nbits),
        .base     (ADDR_W'(pix_idx)),
        .we       (ser_we),
        .addr     (ser_addr),
        .data     (ser_data),
        .last     (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pix_idx     <= '0;
            run_cyc     <= '0;
            label_q     <= '0;
            res_digit   <= '0;
            res_label   <= '0;
            res_match   <= 1'b0;
            img_cnt     <= '0;
            pass_cnt    <= '0;
            batch_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (batch_go) begin
                        state       <= ST_RECV;
                        pix_idx     <= '0;
                        img_cnt     <= '0;
                        pass_cnt    <= '0;
                        batch_done  <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (rx_vld) begin
                        pix_idx <= pix_idx + PIX_W'(nbits);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_last)
                        state <= (pix_idx == PIX_END) ? ST_LABEL : ST_RECV;
                end
                ST_LABEL: begin
                    if (rx_vld) begin
                        label_q <= rx_data[DIGIT_W-1:0];
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    // run_cyc counts cycles since core_start, so the report lands MAX_CYC after it
                    run_cyc <= CYC_W'(1);
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_done) begin
                        res_digit <= core_digit;
                        res_label <= label_q;
                        res_match <= (core_digit == label_q);
                        state     <= ST_REPORT;
                    end else if (run_cyc >= CYC_LAST) begin
                        res_digit   <= '1;
                        res_label   <= label_q;
                        res_match   <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_REPORT;
                    end else begin
                        run_cyc <= run_cyc + CYC_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (img_cnt != CNT_MAX)
                        img_cnt <= img_cnt + CNT_W'(1);
                    if (res_match && (pass_cnt != CNT_MAX))
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    if (img_cnt >= IMG_LAST) begin
                        batch_done <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        pix_idx <= '0;
                        state   <= ST_RECV;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_batch_ctrl.sv
// Bench for snn_batch_ctrl: table-driven and random image batches against a behavioural model,
// plus reset and batch_go-ignore corner sequences.
module tb_snn_batch_ctrl;

    localparam int NUM_PIX = 13;
    localparam int ADDR_W  = 4;
    localparam int DIGIT_W = 4;
    localparam int NUM_IMG = 3;
    localparam int MAX_CYC = 100;
    localparam int CNT_W   = 2;
    localparam int NEVER   = 1000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               batch_go;
    logic [7:0]         rx_data;
    logic               rx_vld;
    logic               rx_rdy;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_data;
    logic [ADDR_W-1:0]  core_addr;
    logic               core_start;
    logic               core_done;
    logic [DIGIT_W-1:0] core_digit;
    logic               res_vld;
    logic [DIGIT_W-1:0] res_digit;
    logic [DIGIT_W-1:0] res_label;
    logic               res_match;
    logic [CNT_W-1:0]   img_cnt;
    logic [CNT_W-1:0]   pass_cnt;
    logic               batch_done;
    logic               timeout_err;

    snn_batch_ctrl #(
        .NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W), .DIGIT_W(DIGIT_W),
        .NUM_IMG(NUM_IMG), .MAX_CYC(MAX_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .batch_go(batch_go),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .core_addr(core_addr), .core_start(core_start), .core_done(core_done),
        .core_digit(core_digit), .res_vld(res_vld), .res_digit(res_digit),
        .res_label(res_label), .res_match(res_match), .img_cnt(img_cnt),
        .pass_cnt(pass_cnt), .batch_done(batch_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] label;
        logic [3:0] cdig;
        int         delay;
        bit         go_run;
        logic [3:0] exp_digit;
        bit         exp_match;
    } vec_t;

    vec_t tbl [0:8];
    vec_t cur [0:NUM_IMG-1];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int start_cnt = 0;
    int mux_err = 0;
    bit run_flag = 1'b0;
    logic [ADDR_W-1:0] wr_addr [$];
    logic              wr_dat  [$];

    int         core_delay = NEVER;
    logic [3:0] core_dig = '0;

    int exp_img;
    int exp_pass;
    bit exp_tmo;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: RAM write log, core_start bookkeeping and RUN-phase address mux.
    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr.push_back(ram_addr);
            wr_dat.push_back(ram_data);
        end
        if (res_vld) run_flag = 1'b0;
        if (run_flag && (ram_addr !== core_addr || ram_we !== 1'b0)) mux_err++;
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
            run_flag  = 1'b1;
        end
    end

    // snn_core stand-in: done pulses core_delay cycles after core_start.
    initial begin
        core_done  = 1'b0;
        core_digit = '0;
        core_addr  = '0;
        forever begin
            @(posedge clk); #1;
            core_addr = ADDR_W'($urandom);
            if (core_start && core_delay < NEVER) begin
                repeat (core_delay) begin
                    @(posedge clk); #1;
                    core_addr = ADDR_W'($urandom);
                end
                core_done  = 1'b1;
                core_digit = core_dig;
                @(posedge clk); #1;
                core_done  = 1'b0;
                core_digit = DIGIT_W'($urandom);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        check(nm, 32'({rx_rdy, ram_we, ram_addr, ram_data, core_start, res_vld, res_digit,
                       res_label, res_match, img_cnt, pass_cnt, batch_done, timeout_err}), 0);
    endtask

    // Reference: result and report latency from the timeout rules.
    function automatic int ref_latency(input int delay);
        return (delay < MAX_CYC) ? delay + 1 : MAX_CYC;
    endfunction

    function automatic vec_t ref_fill(input vec_t v);
        vec_t r;
        bit   timed;
        r = v;
        timed = (v.delay >= MAX_CYC);
        r.exp_digit = timed ? 4'hF : v.cdig;
        r.exp_match = !timed && (r.exp_digit == v.label[3:0]);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int gap;
        ok = 1'b0;
        rx_data = b;
        rx_vld  = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (rx_rdy) ok = 1'b1;
            @(posedge clk); #1;
        end
        gap = $urandom_range(0, 2);
        if (gap != 0) begin
            rx_vld  = 1'b0;
            rx_data = 8'($urandom);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic pulse_go();
        batch_go = 1'b1;
        @(posedge clk); #1;
        batch_go = 1'b0;
    endtask

    task automatic run_image(input vec_t v, input int idx);
        bit          ok;
        bit          got;
        int          bad;
        logic [15:0] pix;
        wr_addr.delete();
        wr_dat.delete();
        start_cnt  = 0;
        mux_err    = 0;
        core_delay = v.delay;
        core_dig   = v.cdig;
        send_byte(v.b0, ok);    check("accept_pix0", 32'(ok), 1);
        send_byte(v.b1, ok);    check("accept_pix1", 32'(ok), 1);
        send_byte(v.label, ok); check("accept_label", 32'(ok), 1);
        rx_vld = 1'b0;
        if (v.go_run) begin
            repeat (5) begin
                @(posedge clk); #1;
            end
            pulse_go();
        end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (res_vld) got = 1'b1;
        end
        check("res_vld_seen", 32'(got), 1);
        if (got) begin
            check("latency", 32'(cyc - start_cyc), 32'(ref_latency(v.delay)));
            check("res_digit", 32'(res_digit), 32'(v.exp_digit));
            check("res_label", 32'(res_label), 32'(v.label[3:0]));
            check("res_match", 32'(res_match), 32'(v.exp_match));
            check("core_start_cnt", 32'(start_cnt), 1);
            check("run_addr_mux", 32'(mux_err), 0);
            pix = {v.b1, v.b0};
            bad = 0;
            foreach (wr_addr[k])
                if (k >= 16 || wr_addr[k] !== ADDR_W'(k) || wr_dat[k] !== pix[k]) bad++;
            check("ram_wr_cnt", 32'(wr_addr.size()), NUM_PIX);
            check("ram_wr_bits", 32'(bad), 0);
            exp_img++;
            if (v.exp_match) exp_pass++;
            if (v.delay >= MAX_CYC) exp_tmo = 1'b1;
            @(negedge clk);
            check("res_vld_pulse", 32'(res_vld), 0);
            check("img_cnt", 32'(img_cnt), 32'(exp_img));
            check("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
            check("timeout_err", 32'(timeout_err), 32'(exp_tmo));
            check("batch_done", 32'(batch_done), 32'(idx == NUM_IMG - 1));
            check("res_digit_hold", 32'(res_digit), 32'(v.exp_digit));
        end
        @(posedge clk); #1;
    endtask

    task automatic run_batch();
        pulse_go();
        exp_img  = 0;
        exp_pass = 0;
        exp_tmo  = 1'b0;
        @(negedge clk);
        check("go_clears", 32'({batch_done, timeout_err, img_cnt, pass_cnt}), 0);
        check("recv_rdy", 32'(rx_rdy), 1);
        @(posedge clk); #1;
        for (int i = 0; i < NUM_IMG; i++) run_image(cur[i], i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        vec_t v;

        //        b0     b1     label  cdig  delay  go   exp_dig exp_match
        tbl[0] = '{8'hA5, 8'h5A, 8'h01, 4'd1,  40,   1'b0, 4'd1,  1'b1};
        tbl[1] = '{8'hFF, 8'hFF, 8'h02, 4'd5,  1,    1'b0, 4'd5,  1'b0};
        tbl[2] = '{8'h00, 8'hE0, 8'h03, 4'd3,  60,   1'b1, 4'd3,  1'b1};
        tbl[3] = '{8'h3C, 8'hC3, 8'h09, 4'd9,  NEVER,1'b0, 4'hF,  1'b0};
        tbl[4] = '{8'h81, 8'h18, 8'h04, 4'd4,  99,   1'b0, 4'd4,  1'b1};
        tbl[5] = '{8'h5A, 8'hA5, 8'h0F, 4'd0,  100,  1'b0, 4'hF,  1'b0};
        tbl[6] = '{8'h01, 8'h80, 8'hF7, 4'd7,  2,    1'b0, 4'd7,  1'b1};
        tbl[7] = '{8'h80, 8'h01, 8'h30, 4'd0,  99,   1'b1, 4'd0,  1'b1};
        tbl[8] = '{8'hFE, 8'h7F, 8'h0A, 4'hB,  50,   1'b0, 4'hB,  1'b0};

        rst_n    = 1'b0;
        batch_go = 1'b0;
        rx_vld   = 1'b0;
        rx_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle_outputs");
        @(posedge clk); #1;

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NUM_IMG; i++) cur[i] = tbl[b * NUM_IMG + i];
            run_batch();
        end

        // Reset in the middle of shifting the first byte, then a clean batch.
        pulse_go();
        send_byte(8'h3C, ok);
        check("accept_pre_rst", 32'(ok), 1);
        rx_vld = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("reset_mid_shift");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_IMG; i++) cur[i] = tbl[i];
        run_batch();

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_IMG; i++) begin
                v.b0     = 8'($urandom);
                v.b1     = 8'($urandom);
                v.label  = 8'($urandom);
                v.cdig   = ($urandom_range(0, 1) == 1) ? v.label[3:0] : 4'($urandom);
                v.delay  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, 105));
                v.go_run = (v.delay >= 20) && ($urandom_range(0, 3) == 0);
                v.exp_digit = '0;
                v.exp_match = 1'b0;
                cur[i] = ref_fill(v);
            end
            run_batch();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
